// File: rtl/load_write_sequencer.sv
// Byte-wide RAM write sequencer for the file-load path.
// Pulls 16-bit words over valid/ready and writes them high byte first.
module load_write_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] ramBase,
  input  logic [ADDR_W-1:0] wordCount,
  input  logic              inValid,
  input  logic [DATA_W-1:0] captured_data,
  output logic              inReady,
  output logic              write,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [BYTE_W-1:0] ramData,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HI,
    S_LO,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] word_q, word_d;

  // State and datapath registers; reset clears everything at once
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic; abort overrides every transition, even a start in IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_d   = ramBase;
            rem_d   = wordCount;
            state_d = (wordCount == '0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (inValid) begin
            word_d  = captured_data;
            state_d = S_HI;
          end
        end
        S_HI: begin
          state_d = S_LO;
        end
        S_LO: begin
          ptr_d   = ptr_q + ADDR_W'(2);
          rem_d   = rem_q - ADDR_W'(1);
          state_d = (rem_q == ADDR_W'(1)) ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    inReady    = 1'b0;
    write      = 1'b0;
    ramAddress = '0;
    ramData    = '0;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    unique case (state_q)
      S_WAIT: begin
        inReady = 1'b1;
      end
      S_HI: begin
        write      = 1'b1;
        ramAddress = ptr_q;
        ramData    = word_q[DATA_W-1:BYTE_W];
      end
      S_LO: begin
        write      = 1'b1;
        ramAddress = ptr_q + ADDR_W'(1);
        ramData    = word_q[BYTE_W-1:0];
      end
      default: begin
        inReady = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_write_sequencer.sv
// Directed bench for load_write_sequencer.
// Expected RAM writes are queued on stimulus and checked as they appear.
module tb_load_write_sequencer;

  logic        clk;
  logic        RST;
  logic        start;
  logic        abort;
  logic [15:0] ramBase;
  logic [15:0] wordCount;
  logic        inValid;
  logic [15:0] captured_data;
  logic        inReady;
  logic        write;
  logic [15:0] ramAddress;
  logic [7:0]  ramData;
  logic        busy;
  logic        done;

  load_write_sequencer #(
    .ADDR_W(16),
    .DATA_W(16),
    .BYTE_W(8)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .start        (start),
    .abort        (abort),
    .ramBase      (ramBase),
    .wordCount    (wordCount),
    .inValid      (inValid),
    .captured_data(captured_data),
    .inReady      (inReady),
    .write        (write),
    .ramAddress   (ramAddress),
    .ramData      (ramData),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_e;
  logic [15:0] nxt_addr;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every write strobe must match the oldest queued byte
  always @(negedge clk) begin
    if (write) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {8'h00, ramAddress, ramData}, 32'hFFFFFFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr_data", {8'h00, ramAddress, ramData}, {8'h00, exp_e});
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_job(logic [15:0] base, logic [15:0] cnt);
    ramBase   = base;
    wordCount = cnt;
    nxt_addr  = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Offer a word and hold valid until accepted; nwr writes are expected
  task automatic offer(logic [15:0] w, int nwr);
    int k;
    k = 0;
    while (!inReady && k < 40) begin
      tick();
      k++;
    end
    check("ready_timeout", {31'd0, inReady}, 32'd1);
    inValid       = 1'b1;
    captured_data = w;
    if (nwr > 0) exp_q.push_back({nxt_addr, w[15:8]});
    if (nwr > 1) exp_q.push_back({nxt_addr + 16'd1, w[7:0]});
    nxt_addr = nxt_addr + 16'd2;
    tick();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    inValid = 1'b0;
    tick();
    check("done_pulse_len", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int t0;
    int dc;
    RST           = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    ramBase       = '0;
    wordCount     = '0;
    inValid       = 1'b0;
    captured_data = '0;
    nxt_addr      = '0;
    tick();
    tick();
    check("rst_inReady", {31'd0, inReady}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_addr", {16'd0, ramAddress}, 32'd0);
    check("rst_data", {24'd0, ramData}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    RST = 1'b0;
    tick();

    // single word
    dc = done_cnt;
    start_job(16'h0100, 16'd1);
    check("one_ready", {31'd0, inReady}, 32'd1);
    offer(16'hABCD, 2);
    inValid = 1'b0;
    check("one_hi_wr", {31'd0, write}, 32'd1);
    tick();
    check("one_lo_wr", {31'd0, write}, 32'd1);
    wait_done();
    check("one_done_cnt", done_cnt - dc, 32'd1);

    // burst with valid held high
    start_job(16'h0010, 16'd3);
    t0 = cyc;
    offer(16'h1122, 2);
    offer(16'h3344, 2);
    offer(16'h5566, 2);
    wait_done();
    check("burst_cycles", done_cyc - t0, 32'd9);

    // stall between words
    start_job(16'h0010, 16'd2);
    offer(16'h1122, 2);
    inValid = 1'b0;
    repeat (7) tick();
    check("stall_ready", {31'd0, inReady}, 32'd1);
    offer(16'h3344, 2);
    wait_done();

    // address wrap
    start_job(16'hFFFE, 16'd2);
    offer(16'h0102, 2);
    offer(16'h0304, 2);
    wait_done();

    // zero-length job
    dc = done_cnt;
    start_job(16'h0700, 16'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    tick();
    check("zero_idle", {31'd0, busy}, 32'd0);
    check("zero_done_cnt", done_cnt - dc, 32'd1);

    // start during a job is ignored
    start_job(16'h0200, 16'd2);
    offer(16'hC0DE, 2);
    inValid   = 1'b0;
    ramBase   = 16'h0900;
    wordCount = 16'd7;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    offer(16'hF00D, 2);
    wait_done();

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);

    // abort during the high-byte write
    dc = done_cnt;
    start_job(16'h0300, 16'd2);
    offer(16'h7788, 1);
    inValid = 1'b0;
    check("abort_in_hi", {31'd0, write}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_write", {31'd0, write}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    check("abort_no_done", done_cnt - dc, 32'd0);
    check("abort_sb", exp_q.size(), 32'd0);

    // job after abort
    start_job(16'h0400, 16'd1);
    offer(16'hBEEF, 2);
    wait_done();

    // reset mid-burst
    start_job(16'h0500, 16'd3);
    offer(16'h1357, 2);
    offer(16'h2468, 1);
    inValid = 1'b0;
    RST = 1'b1;
    #1;
    check("rst_mid_write", {31'd0, write}, 32'd0);
    check("rst_mid_addr", {16'd0, ramAddress}, 32'd0);
    check("rst_mid_data", {24'd0, ramData}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, inReady}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    check("rst_mid_sb", exp_q.size(), 32'd0);

    // job after reset
    start_job(16'h0600, 16'd2);
    offer(16'hA1B2, 2);
    offer(16'hC3D4, 2);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
